// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared definitions for the post-spike reset unit:
//   - reset-mode encodings for cfg_mode
//   - default widths for potential, neuron count and refractory counter
//   - sat_sub: signed saturating subtract evaluated one bit wider than the
//     operands and clamped to the signed range of a caller-chosen width
package neuron_pkg;

  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_NUM_NEURONS = 16;
  localparam int DEFAULT_REFRAC_W    = 4;

  // Working width of sat_sub. Callers sign-extend their operands up to this
  // width, so it supports potentials of up to SAT_MAX_W-1 bits.
  localparam int SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    RST_SUBTRACT  = 2'd0,
    RST_TO_VRESET = 2'd1,
    RST_NONE      = 2'd2,
    RST_RESERVED  = 2'd3   // treated as RST_SUBTRACT
  } reset_mode_e;

  // a - b for operands already sign-extended to SAT_MAX_W bits, clamped to
  // [-2^(w-1), 2^(w-1)-1]. The caller keeps the low w bits of the result.
  function automatic logic [SAT_MAX_W-1:0] sat_sub(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic        [SAT_MAX_W:0] one_v;
    logic signed [SAT_MAX_W:0] diff_v;
    logic signed [SAT_MAX_W:0] max_v;
    logic signed [SAT_MAX_W:0] min_v;
    logic        [SAT_MAX_W-1:0] res_v;
    one_v  = {{SAT_MAX_W{1'b0}}, 1'b1};
    diff_v = $signed({a[SAT_MAX_W-1], a}) - $signed({b[SAT_MAX_W-1], b});
    max_v  = $signed((one_v << (w - 32'd1)) - one_v);
    min_v  = -max_v - $signed(one_v);
    if (diff_v > max_v) begin
      res_v = max_v[SAT_MAX_W-1:0];
    end else if (diff_v < min_v) begin
      res_v = min_v[SAT_MAX_W-1:0];
    end else begin
      res_v = diff_v[SAT_MAX_W-1:0];
    end
    return res_v;
  endfunction

endpackage

// File: rtl/refrac_counter_bank.sv
// refrac_counter_bank
// One refractory down-counter per neuron. A single index addresses both the
// combinational read and the strobed update, which lands on the next edge.
// Ports:
//   clk, rst       clock, asynchronous active-high clear of every counter
//   idx            neuron addressed by the read and by load/dec
//   load, load_val load load_val into counter[idx] (wins over dec)
//   dec            decrement counter[idx], holding at zero
//   cnt            current value of counter[idx]; 0 when idx is out of range
module refrac_counter_bank
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int IDX_W       = $clog2(NUM_NEURONS),
  parameter int REFRAC_W    = DEFAULT_REFRAC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    idx,
  input  logic                load,
  input  logic [REFRAC_W-1:0] load_val,
  input  logic                dec,
  output logic [REFRAC_W-1:0] cnt
);

  localparam logic [REFRAC_W-1:0] CNT_ZERO = {REFRAC_W{1'b0}};
  localparam logic [REFRAC_W-1:0] CNT_ONE  = {{(REFRAC_W-1){1'b0}}, 1'b1};

  logic [REFRAC_W-1:0] cnt_q [NUM_NEURONS];
  logic [REFRAC_W-1:0] cnt_d [NUM_NEURONS];
  logic [31:0]         idx_ext;

  assign idx_ext = 32'(idx);

  // Read mux; indices with no backing counter read as zero.
  always_comb begin
    cnt = CNT_ZERO;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (idx_ext == 32'(i)) begin
        cnt = cnt_q[i];
      end else begin
        cnt = cnt;
      end
    end
  end

  // Next-state: only the addressed counter moves; decrement saturates at zero.
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (idx_ext == 32'(i) && load) begin
        cnt_d[i] = load_val;
      end else if (idx_ext == 32'(i) && dec && (cnt_q[i] != CNT_ZERO)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: rtl/neuron_reset_unit.sv
// neuron_reset_unit
// Registered post-spike reset stage between the potential adder/comparator
// and the membrane-potential memory write port. Takes one update per cycle
// over valid/ready, applies refractory gating and the configured reset mode,
// and presents the write-back potential one cycle after acceptance.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_mode                      0 SUBTRACT, 1 TO_VRESET, 2 NONE, 3 as SUBTRACT
//   cfg_v_reset, cfg_refrac       reset potential, refractory length (0 = off)
//   in_valid / in_ready           input handshake
//   in_idx, in_potential,
//   in_spiked, in_v_threshold     update from the adder/comparator
//   out_valid / out_ready         output handshake
//   out_idx, out_potential,
//   out_spiked, out_refractory,
//   out_err                       registered result; out_err flags a bad index
// Configuration and threshold only matter in the cycle an update is accepted.
module neuron_reset_unit
  import neuron_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int IDX_W       = $clog2(NUM_NEURONS),
  parameter int REFRAC_W    = DEFAULT_REFRAC_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          cfg_mode,
  input  logic [DATA_W-1:0]   cfg_v_reset,
  input  logic [REFRAC_W-1:0] cfg_refrac,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic [DATA_W-1:0]   in_potential,
  input  logic                in_spiked,
  input  logic [DATA_W-1:0]   in_v_threshold,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic [DATA_W-1:0]   out_potential,
  output logic                out_spiked,
  output logic                out_refractory,
  output logic                out_err
);

  localparam int EXT_W = SAT_MAX_W - DATA_W;

  logic                 out_valid_q, out_valid_d;
  logic [IDX_W-1:0]     out_idx_q, out_idx_d;
  logic [DATA_W-1:0]    out_potential_q, out_potential_d;
  logic                 out_spiked_q, out_spiked_d;
  logic                 out_refractory_q, out_refractory_d;
  logic                 out_err_q, out_err_d;

  logic                 accept;
  logic                 idx_in_range;
  logic [REFRAC_W-1:0]  cnt_rd;
  logic                 cnt_load;
  logic                 cnt_dec;
  reset_mode_e          mode;
  logic [SAT_MAX_W-1:0] sub_wide;

  logic [DATA_W-1:0]    res_potential;
  logic                 res_spiked;
  logic                 res_refractory;
  logic                 res_err;

  // A new update may enter whenever the output slot is empty or draining.
  assign in_ready     = !out_valid_q || out_ready;
  assign accept       = in_valid && in_ready;
  assign idx_in_range = (32'(in_idx) < 32'(NUM_NEURONS));
  assign mode         = reset_mode_e'(cfg_mode);

  assign sub_wide = sat_sub({{EXT_W{in_potential[DATA_W-1]}}, in_potential},
                            {{EXT_W{in_v_threshold[DATA_W-1]}}, in_v_threshold},
                            DATA_W);

  refrac_counter_bank #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .REFRAC_W    (REFRAC_W)
  ) u_refrac_bank (
    .clk      (clk),
    .rst      (rst),
    .idx      (in_idx),
    .load     (cnt_load),
    .load_val (cfg_refrac),
    .dec      (cnt_dec),
    .cnt      (cnt_rd)
  );

  // Result of the presented update and the counter action it implies.
  // Counter strobes only fire on acceptance so stalled updates leave state alone.
  always_comb begin
    res_potential  = in_potential;
    res_spiked     = 1'b0;
    res_refractory = 1'b0;
    res_err        = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    if (!idx_in_range) begin
      res_spiked = in_spiked;
      res_err    = 1'b1;
    end else if (cnt_rd != {REFRAC_W{1'b0}}) begin
      res_potential  = cfg_v_reset;
      res_refractory = 1'b1;
      cnt_dec        = accept;
    end else if (in_spiked) begin
      res_spiked = 1'b1;
      cnt_load   = accept;
      case (mode)
        RST_TO_VRESET: res_potential = cfg_v_reset;
        RST_NONE:      res_potential = in_potential;
        default:       res_potential = sub_wide[DATA_W-1:0];
      endcase
    end else begin
      res_potential = in_potential;
    end
  end

  // Output slot: load on accept, empty on drain, otherwise hold steady.
  always_comb begin
    out_valid_d      = out_valid_q;
    out_idx_d        = out_idx_q;
    out_potential_d  = out_potential_q;
    out_spiked_d     = out_spiked_q;
    out_refractory_d = out_refractory_q;
    out_err_d        = out_err_q;
    if (accept) begin
      out_valid_d      = 1'b1;
      out_idx_d        = in_idx;
      out_potential_d  = res_potential;
      out_spiked_d     = res_spiked;
      out_refractory_d = res_refractory;
      out_err_d        = res_err;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register with asynchronous reset; a reset drops any pending result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_idx_q        <= {IDX_W{1'b0}};
      out_potential_q  <= {DATA_W{1'b0}};
      out_spiked_q     <= 1'b0;
      out_refractory_q <= 1'b0;
      out_err_q        <= 1'b0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_idx_q        <= out_idx_d;
      out_potential_q  <= out_potential_d;
      out_spiked_q     <= out_spiked_d;
      out_refractory_q <= out_refractory_d;
      out_err_q        <= out_err_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_idx        = out_idx_q;
  assign out_potential  = out_potential_q;
  assign out_spiked     = out_spiked_q;
  assign out_refractory = out_refractory_q;
  assign out_err        = out_err_q;

endmodule

// File: tb/tb_neuron_reset_unit.sv
// Bench for neuron_reset_unit (NUM_NEURONS=12 so that indices 12..15 exercise
// the out-of-range path). A behavioural model of the update rules runs on the
// falling edge and is compared with the DUT every cycle; directed updates add
// hand-computed literal expectations.
module tb_neuron_reset_unit;

  localparam int DW = 32;
  localparam int NN = 12;
  localparam int IW = 4;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cfg_mode = 2'd0;
  logic [DW-1:0] cfg_v_reset = '0;
  logic [RW-1:0] cfg_refrac = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_idx = '0;
  logic [DW-1:0] in_potential = '0;
  logic          in_spiked = 1'b0;
  logic [DW-1:0] in_v_threshold = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_idx;
  logic [DW-1:0] out_potential;
  logic          out_spiked;
  logic          out_refractory;
  logic          out_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neuron_reset_unit #(
    .DATA_W      (DW),
    .NUM_NEURONS (NN),
    .IDX_W       (IW),
    .REFRAC_W    (RW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_mode       (cfg_mode),
    .cfg_v_reset    (cfg_v_reset),
    .cfg_refrac     (cfg_refrac),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_idx         (in_idx),
    .in_potential   (in_potential),
    .in_spiked      (in_spiked),
    .in_v_threshold (in_v_threshold),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_idx        (out_idx),
    .out_potential  (out_potential),
    .out_spiked     (out_spiked),
    .out_refractory (out_refractory),
    .out_err        (out_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_valid = 1'b0;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] m_pot;
  logic          m_spk, m_refr, m_err;
  int            m_cnt [NN];
  int            mi;
  longint        md;

  // Falling edge: compare against the model, then advance the model by the
  // update (if any) that the coming rising edge will take.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      m_valid = 1'b0;
      for (int i = 0; i < NN; i++) m_cnt[i] = 0;
    end else begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
      if (m_valid) begin
        check("out_idx", 64'(out_idx), 64'(m_idx));
        check("out_potential", 64'(out_potential), 64'(m_pot));
        check("out_spiked", 64'(out_spiked), 64'(m_spk));
        check("out_refractory", 64'(out_refractory), 64'(m_refr));
        check("out_err", 64'(out_err), 64'(m_err));
      end
      if (in_valid && (!m_valid || out_ready)) begin
        mi      = int'(in_idx);
        m_valid = 1'b1;
        m_idx   = in_idx;
        m_refr  = 1'b0;
        m_err   = 1'b0;
        m_spk   = 1'b0;
        m_pot   = in_potential;
        if (mi >= NN) begin
          m_err = 1'b1;
          m_spk = in_spiked;
        end else if (m_cnt[mi] > 0) begin
          m_pot  = cfg_v_reset;
          m_refr = 1'b1;
          m_cnt[mi] = m_cnt[mi] - 1;
        end else if (in_spiked) begin
          m_spk     = 1'b1;
          m_cnt[mi] = int'(cfg_refrac);
          if (cfg_mode == 2'd1) begin
            m_pot = cfg_v_reset;
          end else if (cfg_mode == 2'd2) begin
            m_pot = in_potential;
          end else begin
            md = longint'($signed(in_potential)) - longint'($signed(in_v_threshold));
            if (md > 64'sd2147483647) m_pot = 32'h7fff_ffff;
            else if (md < -64'sd2147483648) m_pot = 32'h8000_0000;
            else m_pot = md[31:0];
          end
        end
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Called just after a rising edge with out_ready=1 and the output slot empty.
  task automatic send(input string name, input logic [IW-1:0] idx, input logic [DW-1:0] pot,
                      input logic spk, input logic [DW-1:0] thr, input logic [DW-1:0] e_pot,
                      input logic e_spk, input logic e_refr, input logic e_err);
    in_idx = idx; in_potential = pot; in_spiked = spk; in_v_threshold = thr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_idx"}, 64'(out_idx), 64'(idx));
    check({name, "_pot"}, 64'(out_potential), 64'(e_pot));
    check({name, "_spk"}, 64'(out_spiked), 64'(e_spk));
    check({name, "_refr"}, 64'(out_refractory), 64'(e_refr));
    check({name, "_err"}, 64'(out_err), 64'(e_err));
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rand_pot();
    logic [DW-1:0] v;
    case ($urandom_range(0, 3))
      0: v = DW'($urandom);
      1: v = 32'h8000_0000 + DW'($urandom_range(0, 300));
      2: v = 32'h7fff_ffff - DW'($urandom_range(0, 300));
      default: v = DW'($urandom_range(0, 400)) - 32'd200;
    endcase
    return v;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_pot", 64'(out_potential), 64'd0);
    check("reset_out_idx", 64'(out_idx), 64'd0);
    rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // SUBTRACT, no refractory window
    cfg_mode = 2'd0; cfg_refrac = 4'd0; cfg_v_reset = 32'd0;
    send("sub_basic", 4'd3, 32'd150, 1'b1, 32'd100, 32'd50, 1'b1, 1'b0, 1'b0);
    send("sub_sat_min", 4'd3, 32'h8000_0005, 1'b1, 32'd100, 32'h8000_0000, 1'b1, 1'b0, 1'b0);
    send("sub_sat_max", 4'd4, 32'h7fff_fff0, 1'b1, 32'hffff_ff00, 32'h7fff_ffff, 1'b1, 1'b0, 1'b0);

    // TO_VRESET with a two-update refractory window
    cfg_mode = 2'd1; cfg_v_reset = -32'sd10; cfg_refrac = 4'd2;
    send("vr_spike", 4'd5, 32'd500, 1'b1, 32'd100, -32'sd10, 1'b1, 1'b0, 1'b0);
    send("vr_refr1", 4'd5, 32'd500, 1'b1, 32'd100, -32'sd10, 1'b0, 1'b1, 1'b0);
    send("vr_refr2", 4'd5, 32'd500, 1'b1, 32'd100, -32'sd10, 1'b0, 1'b1, 1'b0);
    send("vr_again", 4'd5, 32'd500, 1'b1, 32'd100, -32'sd10, 1'b1, 1'b0, 1'b0);

    // NONE mode and pass-through
    cfg_mode = 2'd2; cfg_refrac = 4'd0;
    send("none_nospk", 4'd9, -32'sd7, 1'b0, 32'd100, -32'sd7, 1'b0, 1'b0, 1'b0);
    send("none_spk", 4'd9, 32'd120, 1'b1, 32'd100, 32'd120, 1'b1, 1'b0, 1'b0);

    // index beyond the neuron array
    send("bad_idx", 4'(NN), 32'd77, 1'b1, 32'd10, 32'd77, 1'b1, 1'b0, 1'b1);

    // backpressure: one accept, then three stalled cycles, then drain
    out_ready = 1'b0;
    in_idx = 4'd1; in_potential = 32'd111; in_spiked = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_first_valid", 64'(out_valid), 64'd1);
    in_idx = 4'd2; in_potential = 32'd222;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_pot", 64'(out_potential), 64'd111);
      check("bp_hold_idx", 64'(out_idx), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_pot", 64'(out_potential), 64'd222);
    check("bp_second_idx", 64'(out_idx), 64'd2);
    @(posedge clk); #1;
    check("bp_drained", 64'(out_valid), 64'd0);

    // reset with a pending result, counters must clear
    cfg_mode = 2'd0; cfg_refrac = 4'd3; cfg_v_reset = 32'd4;
    send("pre_rst_spike", 4'd7, 32'd20, 1'b1, 32'd10, 32'd10, 1'b1, 1'b0, 1'b0);
    send("pre_rst_refr", 4'd7, 32'd20, 1'b1, 32'd10, 32'd4, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_idx = 4'd0; in_potential = 32'd5; in_spiked = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pend_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_pot", 64'(out_potential), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send("post_rst_spike", 4'd7, 32'd20, 1'b1, 32'd10, 32'd10, 1'b1, 1'b0, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      in_valid       = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      in_idx         = IW'($urandom_range(0, 15));
      in_spiked      = ($urandom_range(0, 1) != 0);
      in_potential   = rand_pot();
      in_v_threshold = rand_pot();
      cfg_mode       = 2'($urandom_range(0, 3));
      cfg_v_reset    = rand_pot();
      cfg_refrac     = RW'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
